// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Brief    : Shared types for the load/store stage and its lane aligner.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        eLb, eLh, eLw, eLbu, eLhu, eSb, eSh, eSw
    } tLsuFunct3;

    typedef enum logic [1:0] {
        eExcNone     = 2'b00,
        eExcMisalign = 2'b01,
        eExcIllegal  = 2'b10,
        eExcBusTo    = 2'b11
    } tExcCause;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rdAddr;
        logic [31:0] data;
    } tWbOut;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tMemBus;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        EXC  = 2'd3
    } tLsuState;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    localparam logic [1:0] c_size_b = 2'd0;
    localparam logic [1:0] c_size_h = 2'd1;
    localparam logic [1:0] c_size_w = 2'd2;

    function automatic logic [1:0] op_size(input tLsuFunct3 op);
        logic [1:0] size;
        case (op)
            eLb, eLbu, eSb: size = c_size_b;
            eLh, eLhu, eSh: size = c_size_h;
            default:        size = c_size_w;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Access decode, store lane replication/byte enables, load extraction.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    input  logic        i_read,
    input  logic        i_write,
    output tLsuFunct3   o_op,
    output logic        o_illegal,
    output logic        o_misalign,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  tLsuFunct3   i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [1:0]  w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_op      = eLw;
        o_illegal = 1'b0;
        if (i_read && i_write) begin
            o_illegal = 1'b1;
        end else if (i_read) begin
            case (i_funct3)
                c_f3_b:  o_op = eLb;
                c_f3_h:  o_op = eLh;
                c_f3_w:  o_op = eLw;
                c_f3_bu: o_op = eLbu;
                c_f3_hu: o_op = eLhu;
                default: o_illegal = 1'b1;
            endcase
        end else if (i_write) begin
            case (i_funct3)
                c_f3_b:  o_op = eSb;
                c_f3_h:  o_op = eSh;
                c_f3_w:  o_op = eSw;
                default: o_illegal = 1'b1;
            endcase
        end
    end

    assign w_size = op_size(o_op);

    // Illegal wins over misaligned, and a no-op record is never misaligned.
    always_comb begin
        o_misalign = 1'b0;
        if (!o_illegal && (i_read || i_write)) begin
            if (w_size == c_size_h)
                o_misalign = i_addr[0];
            else if (w_size == c_size_w)
                o_misalign = (i_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_data;
        case (w_size)
            c_size_b: begin
                o_be    = 4'b0001 << i_addr[1:0];
                o_wdata = {4{i_data[7:0]}};
            end
            c_size_h: begin
                o_be    = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata = {2{i_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = 8'(i_rdata >> {i_ld_off, 3'b000});
    assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_op)
            eLb:     o_ld_data = {{24{w_byte[7]}}, w_byte};
            eLbu:    o_ld_data = {24'd0, w_byte};
            eLh:     o_ld_data = {{16{w_half[15]}}, w_half};
            eLhu:    o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Load/store stage: one req/ack bus transaction per ALU record.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    output logic        oReady,
    input  logic [31:0] iAddr,
    input  logic [31:0] iData,
    input  logic [4:0]  iRdAddr,
    input  logic [2:0]  iFunct3,
    input  logic        iRead,
    input  logic        iWrite,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemBe,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic        oWbValid,
    output logic [4:0]  oWbRdAddr,
    output logic [31:0] oWbData,
    output logic [1:0]  oExc,
    output logic [31:0] oExcAddr
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    tLsuState         state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    tLsuFunct3        op_q,       op_d;
    logic [31:0]      addr_q,     addr_d;
    logic [4:0]       rd_q,       rd_d;
    tMemBus           mem_q,      mem_d;
    tWbOut            wb_q,       wb_d;
    tExcCause         exc_q,      exc_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    tLsuFunct3   w_op;
    logic        w_illegal;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    lsu_align u_lsu_align (
        .i_addr     (iAddr),
        .i_data     (iData),
        .i_funct3   (iFunct3),
        .i_read     (iRead),
        .i_write    (iWrite),
        .o_op       (w_op),
        .o_illegal  (w_illegal),
        .o_misalign (w_misalign),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ld_op    (op_q),
        .i_ld_off   (addr_q[1:0]),
        .i_rdata    (iMemRData),
        .o_ld_data  (w_ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        mem_d      = mem_q;
        wb_d       = '0;
        exc_d      = eExcNone;
        exc_addr_d = '0;

        case (state_q)
            IDLE: begin
                if (iValid) begin
                    if (w_illegal) begin
                        state_d    = EXC;
                        exc_d      = eExcIllegal;
                        exc_addr_d = iAddr;
                    end else if (w_misalign) begin
                        state_d    = EXC;
                        exc_d      = eExcMisalign;
                        exc_addr_d = iAddr;
                    end else if (iRead || iWrite) begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        op_d        = w_op;
                        addr_d      = iAddr;
                        rd_d        = iRdAddr;
                        mem_d.req   = 1'b1;
                        mem_d.we    = iWrite;
                        mem_d.addr  = {iAddr[31:2], 2'b00};
                        mem_d.be    = w_be;
                        mem_d.wdata = iWrite ? w_wdata : 32'd0;
                    end
                end
            end
            BUSY: begin
                // An ack in the final timeout cycle still completes the access.
                if (iMemAck) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    mem_d   = '0;
                    if (!mem_q.we && (rd_q != 5'd0)) begin
                        wb_d.valid  = 1'b1;
                        wb_d.rdAddr = rd_q;
                        wb_d.data   = w_ld_data;
                    end
                end else if (cnt_q == c_cnt_last) begin
                    state_d    = EXC;
                    cnt_d      = '0;
                    mem_d      = '0;
                    exc_d      = eExcBusTo;
                    exc_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= eLw;
            addr_q     <= '0;
            rd_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            exc_q      <= eExcNone;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign oReady    = (state_q == IDLE);
    assign oMemReq   = mem_q.req;
    assign oMemWe    = mem_q.we;
    assign oMemAddr  = mem_q.addr;
    assign oMemWData = mem_q.wdata;
    assign oMemBe    = mem_q.be;
    assign oWbValid  = wb_q.valid;
    assign oWbRdAddr = wb_q.rdAddr;
    assign oWbData   = wb_q.data;
    assign oExc      = exc_q;
    assign oExcAddr  = exc_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed self-checking bench for mem_access_stage (TIMEOUT_CYC = 4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [31:0] iAddr = '0;
    logic [31:0] iData = '0;
    logic [4:0]  iRdAddr = '0;
    logic [2:0]  iFunct3 = '0;
    logic        iRead = 1'b0;
    logic        iWrite = 1'b0;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemBe;
    logic        iMemAck = 1'b0;
    logic [31:0] iMemRData = '0;
    logic        oWbValid;
    logic [4:0]  oWbRdAddr;
    logic [31:0] oWbData;
    logic [1:0]  oExc;
    logic [31:0] oExcAddr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iAddr     (iAddr),
        .iData     (iData),
        .iRdAddr   (iRdAddr),
        .iFunct3   (iFunct3),
        .iRead     (iRead),
        .iWrite    (iWrite),
        .oMemReq   (oMemReq),
        .oMemWe    (oMemWe),
        .oMemAddr  (oMemAddr),
        .oMemWData (oMemWData),
        .oMemBe    (oMemBe),
        .iMemAck   (iMemAck),
        .iMemRData (iMemRData),
        .oWbValid  (oWbValid),
        .oWbRdAddr (oWbRdAddr),
        .oWbData   (oWbData),
        .oExc      (oExc),
        .oExcAddr  (oExcAddr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    // Presents one record for a single accept edge, then withdraws it.
    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rda);
        iValid  = 1'b1;
        iRead   = rd;
        iWrite  = wr;
        iFunct3 = f3;
        iAddr   = addr;
        iData   = data;
        iRdAddr = rda;
        chk("ready_before_accept", oReady, 1);
        tick;
        iValid = 1'b0;
        iRead  = 1'b0;
        iWrite = 1'b0;
    endtask

    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [4:0] rda,
                              input int waits, input logic [31:0] rdata,
                              input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_wbv,
                              input logic [31:0] exp_wbdata);
        present(rd, wr, f3, addr, data, rda);
        chk({tag, "_req"},   oMemReq, 1);
        chk({tag, "_we"},    oMemWe, wr);
        chk({tag, "_maddr"}, oMemAddr, exp_maddr);
        chk({tag, "_be"},    oMemBe, exp_be);
        chk({tag, "_ready_busy"}, oReady, 0);
        if (wr) chk({tag, "_wdata"}, oMemWData, exp_wdata);
        for (int k = 0; k < waits; k++) begin
            tick;
            chk({tag, "_req_hold"},   oMemReq, 1);
            chk({tag, "_maddr_hold"}, oMemAddr, exp_maddr);
        end
        iMemAck   = 1'b1;
        iMemRData = rdata;
        tick;
        iMemAck   = 1'b0;
        iMemRData = 32'h0;
        chk({tag, "_resp_req"},   oMemReq, 0);
        chk({tag, "_resp_ready"}, oReady, 0);
        chk({tag, "_wbvalid"},    oWbValid, exp_wbv);
        if (exp_wbv) begin
            chk({tag, "_wbrd"},   oWbRdAddr, rda);
            chk({tag, "_wbdata"}, oWbData, exp_wbdata);
        end
        tick;
        chk({tag, "_idle_ready"}, oReady, 1);
        chk({tag, "_wb_pulse"},   oWbValid, 0);
    endtask

    task automatic run_exc(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [1:0] exp_exc);
        present(rd, wr, f3, addr, 32'h0, 5'd1);
        chk({tag, "_exc"},      oExc, exp_exc);
        chk({tag, "_excaddr"},  oExcAddr, addr);
        chk({tag, "_noreq"},    oMemReq, 0);
        chk({tag, "_ready"},    oReady, 0);
        tick;
        chk({tag, "_exc_pulse"}, oExc, 0);
        chk({tag, "_noreq2"},    oMemReq, 0);
        chk({tag, "_ready2"},    oReady, 1);
    endtask

    initial begin
        int cyc;
        #12;
        chk("rst_ready",   oReady, 1);
        chk("rst_req",     oMemReq, 0);
        chk("rst_maddr",   oMemAddr, 0);
        chk("rst_be",      oMemBe, 0);
        chk("rst_wbvalid", oWbValid, 0);
        chk("rst_exc",     oExc, 0);
        chk("rst_excaddr", oExcAddr, 0);
        iRst = 1'b1;
        tick;

        // Ack in the last allowed request cycle still completes the load.
        run_access("lw",   1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF,
                   32'h100, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF);
        run_access("lb",   1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5'd7, 1, 32'h80FFFF7F,
                   32'h200, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80);
        run_access("lbu",  1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5'd7, 0, 32'h80FFFF7F,
                   32'h200, 4'b1000, 32'h0, 1'b1, 32'h00000080);
        run_access("lhu",  1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 5'd8, 2, 32'h80FFFF7F,
                   32'h200, 4'b1100, 32'h0, 1'b1, 32'h000080FF);
        run_access("lh",   1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 5'd9, 0, 32'h80FFFF7F,
                   32'h200, 4'b1100, 32'h0, 1'b1, 32'hFFFF80FF);
        run_access("lb0",  1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 5'd10, 0, 32'h80FFFF7F,
                   32'h200, 4'b0001, 32'h0, 1'b1, 32'h0000007F);
        run_access("sb",   1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd0, 1, 32'h0,
                   32'h300, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0);
        run_access("sh",   1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 5'd4, 0, 32'h0,
                   32'h300, 4'b1100, 32'h12341234, 1'b0, 32'h0);
        run_access("sw",   1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 5'd4, 0, 32'hFFFFFFFF,
                   32'h304, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
        run_access("lwrd0", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd0, 0, 32'h11111111,
                   32'h400, 4'b1111, 32'h0, 1'b0, 32'h0);

        run_exc("mis_lw",   1'b1, 1'b0, 3'b010, 32'h102, 2'b01);
        run_exc("mis_lh",   1'b1, 1'b0, 3'b001, 32'h201, 2'b01);
        run_exc("mis_sw",   1'b0, 1'b1, 3'b010, 32'h306, 2'b01);
        run_exc("ill_rw",   1'b1, 1'b1, 3'b010, 32'h100, 2'b10);
        run_exc("ill_ld",   1'b1, 1'b0, 3'b011, 32'h100, 2'b10);
        run_exc("ill_st",   1'b0, 1'b1, 3'b100, 32'h100, 2'b10);
        run_exc("ill_prio", 1'b1, 1'b0, 3'b110, 32'h003, 2'b10);

        present(1'b0, 1'b0, 3'b010, 32'h123, 32'h0, 5'd3);
        chk("noop_req",   oMemReq, 0);
        chk("noop_ready", oReady, 1);
        chk("noop_exc",   oExc, 0);

        // Bus timeout: request is held exactly TIMEOUT_CYC cycles.
        present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd3);
        cyc = 0;
        while (oMemReq === 1'b1 && cyc < 10) begin
            cyc++;
            tick;
        end
        chk("to_req_cycles", cyc, 4);
        chk("to_exc",        oExc, 2'b11);
        chk("to_excaddr",    oExcAddr, 32'h500);
        chk("to_ready_exc",  oReady, 0);
        iMemAck   = 1'b1;
        iMemRData = 32'h55AA55AA;
        tick;
        chk("to_idle_ready",   oReady, 1);
        chk("to_exc_pulse",    oExc, 0);
        chk("late_ack_wb",     oWbValid, 0);
        tick;
        chk("late_ack_wb2",    oWbValid, 0);
        chk("late_ack_req",    oMemReq, 0);
        chk("late_ack_ready",  oReady, 1);
        iMemAck   = 1'b0;
        iMemRData = 32'h0;

        // Asynchronous reset while a request is outstanding.
        present(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd9);
        chk("rstbusy_req_pre", oMemReq, 1);
        #2 iRst = 1'b0;
        #1;
        chk("rstbusy_req",   oMemReq, 0);
        chk("rstbusy_ready", oReady, 1);
        chk("rstbusy_maddr", oMemAddr, 0);
        #2 iRst = 1'b1;
        tick;
        chk("post_rst_req",   oMemReq, 0);
        chk("post_rst_ready", oReady, 1);
        chk("post_rst_wb",    oWbValid, 0);

        run_access("lw_after", 1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 5'd31, 0, 32'h01234567,
                   32'h700, 4'b1111, 32'h0, 1'b1, 32'h01234567);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
